// File: rtl/stream_arbiter_pkg.sv
// Shared types and sizing helpers for the QoS stream arbiter.
//   arb_state_t : arbiter FSM states
//   id_width()  : width of a stream-index field for a given stream count
package stream_arbiter_pkg;

    // Arbiter FSM: IDLE picks a winner, BUSY forwards the granted packet.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned DEFAULT_STREAM_COUNT = 2;
    localparam int unsigned DEFAULT_DATA_WIDTH   = 8;
    localparam int unsigned DEFAULT_QOS_WIDTH    = 4;

    // Index width for n streams; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEFAULT_ID_WIDTH = id_width(DEFAULT_STREAM_COUNT);

endpackage : stream_arbiter_pkg

// File: rtl/stream_arbiter_qos_select.sv
// Combinational QoS winner selection.
// Picks the eligible stream with the largest QoS; ties resolve to the
// lowest index. QoS 0 still wins when it is the only eligible stream.
//   qos_i      : per-stream QoS values
//   elig_i     : per-stream eligibility mask
//   win_idx_o  : index of the winning stream (0 when none eligible)
//   win_qos_o  : QoS of the winning stream (0 when none eligible)
//   any_elig_o : at least one stream is eligible
module qos_select
    import stream_arbiter_pkg::*;
#(
    parameter int unsigned N  = DEFAULT_STREAM_COUNT,
    parameter int unsigned QW = DEFAULT_QOS_WIDTH,
    parameter int unsigned IW = id_width(N)
) (
    input  logic [N-1:0][QW-1:0] qos_i,
    input  logic [N-1:0]         elig_i,
    output logic [IW-1:0]        win_idx_o,
    output logic [QW-1:0]        win_qos_o,
    output logic                 any_elig_o
);

    logic [IW-1:0] best_idx;
    logic [QW-1:0] best_qos;
    logic          found;

    // Strict '>' keeps the earlier (lower) index on equal QoS.
    always_comb begin
        best_idx = '0;
        best_qos = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (elig_i[i] && (!found || (qos_i[i] > best_qos))) begin
                best_idx = IW'(i);
                best_qos = qos_i[i];
                found    = 1'b1;
            end
        end
    end

    assign win_idx_o  = best_idx;
    assign win_qos_o  = best_qos;
    assign any_elig_o = found;

endmodule : qos_select

// File: rtl/stream_arbiter.sv
// QoS stream arbiter with per-round fairness and packet-level grant hold.
// Each round serves every requesting stream at most once, highest QoS
// first; the grant is held until the beat carrying last is accepted.
// While BUSY the master port is a combinational pass-through of the
// granted slave, so packets stream at one beat per cycle.
//   clk, rst_n             : clock, asynchronous active-low reset
//   s_data_i/s_qos_i/
//   s_last_i/s_valid_i     : per-stream slave inputs
//   s_ready_o              : per-stream ready (only the granted bit moves)
//   m_data_o/m_qos_o/
//   m_id_o/m_last_o/
//   m_valid_o              : master output stream
//   m_ready_i              : downstream ready
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned T_QOS__WIDTH = DEFAULT_QOS_WIDTH,
    parameter int unsigned STREAM_COUNT = DEFAULT_STREAM_COUNT,
    parameter int unsigned T_ID___WIDTH = id_width(STREAM_COUNT)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i,
    input  logic [STREAM_COUNT-1:0]                s_last_i,
    input  logic [STREAM_COUNT-1:0]                s_valid_i,
    output logic [STREAM_COUNT-1:0]                s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                m_data_o,
    output logic [T_QOS__WIDTH-1:0]                m_qos_o,
    output logic [T_ID___WIDTH-1:0]                m_id_o,
    output logic                                   m_last_o,
    output logic                                   m_valid_o,
    input  logic                                   m_ready_i
);

    arb_state_t                state_q;
    logic [STREAM_COUNT-1:0]   served_q;
    logic [T_ID___WIDTH-1:0]   grant_q;
    logic [T_QOS__WIDTH-1:0]   grant_qos_q;

    logic [STREAM_COUNT-1:0]   elig_raw;
    logic                      round_over;
    logic [STREAM_COUNT-1:0]   elig;
    logic [T_ID___WIDTH-1:0]   win_idx;
    logic [T_QOS__WIDTH-1:0]   win_qos;
    logic                      any_elig;
    logic                      last_beat;

    // Round ends when every requester has been served; restart from all valid.
    assign elig_raw   = s_valid_i & ~served_q;
    assign round_over = (elig_raw == '0) && (s_valid_i != '0);
    assign elig       = round_over ? s_valid_i : elig_raw;

    qos_select #(
        .N  (STREAM_COUNT),
        .QW (T_QOS__WIDTH),
        .IW (T_ID___WIDTH)
    ) u_qos_select (
        .qos_i      (s_qos_i),
        .elig_i     (elig),
        .win_idx_o  (win_idx),
        .win_qos_o  (win_qos),
        .any_elig_o (any_elig)
    );

    assign last_beat = s_valid_i[grant_q] & m_ready_i & s_last_i[grant_q];

    // Arbiter FSM, served mask and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            served_q    <= '0;
            grant_q     <= '0;
            grant_qos_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (round_over) begin
                        served_q <= '0;
                    end
                    if (any_elig) begin
                        grant_q     <= win_idx;
                        grant_qos_q <= win_qos;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    // No preemption: only the last accepted beat releases the grant.
                    if (last_beat) begin
                        served_q[grant_q] <= 1'b1;
                        state_q           <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output mux: pass-through of the granted stream while BUSY, zero otherwise.
    always_comb begin
        s_ready_o = '0;
        m_data_o  = '0;
        m_qos_o   = '0;
        m_id_o    = '0;
        m_last_o  = 1'b0;
        m_valid_o = 1'b0;
        if (state_q == BUSY) begin
            s_ready_o[grant_q] = m_ready_i;
            m_data_o           = s_data_i[grant_q];
            m_qos_o            = grant_qos_q;
            m_id_o             = grant_q;
            m_last_o           = s_last_i[grant_q];
            m_valid_o          = s_valid_i[grant_q];
        end
    end

endmodule : stream_arbiter

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: reset, QoS priority, tie fairness,
// packet lock, backpressure/stall, QoS 0 single requester, async reset.
module tb_stream_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned QW = 4;
    localparam int unsigned SC = 2;
    localparam int unsigned IW = 1;

    logic                      clk;
    logic                      rst_n;
    logic [SC-1:0][DW-1:0]     s_data_i;
    logic [SC-1:0][QW-1:0]     s_qos_i;
    logic [SC-1:0]             s_last_i;
    logic [SC-1:0]             s_valid_i;
    logic [SC-1:0]             s_ready_o;
    logic [DW-1:0]             m_data_o;
    logic [QW-1:0]             m_qos_o;
    logic [IW-1:0]             m_id_o;
    logic                      m_last_o;
    logic                      m_valid_o;
    logic                      m_ready_i;

    int total;
    int bad;

    stream_arbiter #(
        .T_DATA_WIDTH (DW),
        .T_QOS__WIDTH (QW),
        .STREAM_COUNT (SC),
        .T_ID___WIDTH (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data_i),
        .s_qos_i   (s_qos_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_qos_o   (m_qos_o),
        .m_id_o    (m_id_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; land 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_beat(input string tag, input int id, input int qos,
                               input int data, input int last);
        #1;
        check_eq({tag, ".valid"}, 32'(m_valid_o), 32'd1);
        check_eq({tag, ".id"},    32'(m_id_o),    32'(id));
        check_eq({tag, ".qos"},   32'(m_qos_o),   32'(qos));
        check_eq({tag, ".data"},  32'(m_data_o),  32'(data));
        check_eq({tag, ".last"},  32'(m_last_o),  32'(last));
        check_eq({tag, ".sready"}, 32'(s_ready_o), m_ready_i ? (32'd1 << id) : 32'd0);
    endtask

    task automatic expect_idle(input string tag);
        #1;
        check_eq({tag, ".valid"},  32'(m_valid_o), 32'd0);
        check_eq({tag, ".sready"}, 32'(s_ready_o), 32'd0);
    endtask

    task automatic expect_zero(input string tag);
        check_eq({tag, ".sready"}, 32'(s_ready_o), 32'd0);
        check_eq({tag, ".valid"},  32'(m_valid_o), 32'd0);
        check_eq({tag, ".data"},   32'(m_data_o),  32'd0);
        check_eq({tag, ".qos"},    32'(m_qos_o),   32'd0);
        check_eq({tag, ".id"},     32'(m_id_o),    32'd0);
        check_eq({tag, ".last"},   32'(m_last_o),  32'd0);
    endtask

    // Short mid-cycle reset pulse to start each scenario from a clean state.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_s(input int idx, input logic v, input logic [7:0] d,
                         input logic [3:0] q, input logic l);
        s_valid_i[idx] = v;
        s_data_i[idx]  = d;
        s_qos_i[idx]   = q;
        s_last_i[idx]  = l;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        s_data_i  = '0;
        s_qos_i   = '0;
        s_last_i  = '0;
        s_valid_i = '0;
        m_ready_i = 1'b1;

        // Reset held with every stream requesting.
        set_s(0, 1'b1, 8'hA0, 4'd3, 1'b1);
        set_s(1, 1'b1, 8'hB1, 4'd9, 1'b1);
        tick();
        tick();
        #1;
        expect_zero("rst");

        // Priority: S1 (qos 9) first, S0 next round slot, then S1 again.
        rst_n = 1'b1;
        expect_idle("pri.idle0");
        tick(); expect_beat("pri.b0", 1, 9, 8'hB1, 1);
        tick(); expect_idle("pri.bub0");
        tick(); expect_beat("pri.b1", 0, 3, 8'hA0, 1);
        tick(); expect_idle("pri.bub1");
        tick(); expect_beat("pri.b2", 1, 9, 8'hB1, 1);
        tick();
        s_valid_i = '0;

        // Tie at qos 5: grants alternate 0,1,0,1.
        tick();
        pulse_reset();
        set_s(0, 1'b1, 8'h50, 4'd5, 1'b1);
        set_s(1, 1'b1, 8'h51, 4'd5, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(); expect_beat($sformatf("tie.b%0d", k), k % 2, 5, 8'h50 + (k % 2), 1);
            tick(); expect_idle($sformatf("tie.bub%0d", k));
        end
        s_valid_i = '0;

        // Packet lock: S0 4-beat packet at qos 2, S1 raises to 15 mid-packet.
        tick();
        pulse_reset();
        set_s(0, 1'b1, 8'h10, 4'd2, 1'b0);
        set_s(1, 1'b1, 8'h55, 4'd1, 1'b1);
        tick(); expect_beat("lock.b0", 0, 2, 8'h10, 0);
        tick();
        s_data_i[0] = 8'h11;
        s_qos_i[1]  = 4'd15;
        expect_beat("lock.b1", 0, 2, 8'h11, 0);
        tick();
        s_data_i[0] = 8'h12;
        expect_beat("lock.b2", 0, 2, 8'h12, 0);
        tick();
        s_data_i[0] = 8'h13;
        s_last_i[0] = 1'b1;
        expect_beat("lock.b3", 0, 2, 8'h13, 1);
        tick();
        s_valid_i[0] = 1'b0;
        expect_idle("lock.bub");
        tick(); expect_beat("lock.s1", 1, 15, 8'h55, 1);
        tick();
        s_valid_i = '0;

        // Backpressure then source stall; a higher-QoS arrival must not preempt.
        tick();
        pulse_reset();
        set_s(0, 1'b1, 8'h21, 4'd4, 1'b0);
        set_s(1, 1'b0, 8'h99, 4'd15, 1'b1);
        tick();
        m_ready_i = 1'b0;
        s_valid_i[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_beat($sformatf("bp.hold%0d", k), 0, 4, 8'h21, 0);
            tick();
        end
        m_ready_i = 1'b1;
        expect_beat("bp.go", 0, 4, 8'h21, 0);
        tick();
        s_valid_i[0] = 1'b0;
        s_data_i[0]  = 8'h22;
        s_last_i[0]  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq($sformatf("stall%0d.valid", k), 32'(m_valid_o), 32'd0);
            check_eq($sformatf("stall%0d.id", k),    32'(m_id_o),    32'd0);
            check_eq($sformatf("stall%0d.sready", k), 32'(s_ready_o), 32'd1);
            tick();
        end
        s_valid_i[0] = 1'b1;
        expect_beat("stall.end", 0, 4, 8'h22, 1);
        tick();
        s_valid_i[0] = 1'b0;
        expect_idle("stall.bub");
        tick(); expect_beat("stall.s1", 1, 15, 8'h99, 1);
        tick();
        s_valid_i = '0;

        // QoS 0, single requester: re-granted every round with one bubble.
        tick();
        pulse_reset();
        set_s(0, 1'b0, 8'h00, 4'd7, 1'b1);
        set_s(1, 1'b1, 8'h77, 4'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(); expect_beat($sformatf("q0.b%0d", k), 1, 0, 8'h77, 1);
            tick(); expect_idle($sformatf("q0.bub%0d", k));
        end
        s_valid_i = '0;

        // Asynchronous reset while BUSY clears outputs without a clock edge.
        tick();
        pulse_reset();
        set_s(0, 1'b1, 8'h3C, 4'd1, 1'b0);
        tick(); expect_beat("arst.pre", 0, 1, 8'h3C, 0);
        rst_n = 1'b0;
        #1;
        expect_zero("arst");
        tick();
        #1;
        expect_zero("arst.hold");
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stream_arbiter
